lego_fpga_axis64_kvs: RTL and testbench
=======================================

# lego_fpga_axis64_kvs

Single-clock key-value store that sits behind the 64-bit network AXI-Stream path. It parses GET/SET/DELETE request packets from `from_net_*` and looks them up in an on-chip direct-mapped hash table. It answers each request with a fixed 2-beat response packet on `to_net_*`. It is the on-chip, DRAM-free version of the KVS block, usable standalone or as the lookup core of the larger design.

## Interface
- `TABLE_AW`, default 8: log2 of the number of table entries (256 by default).
- `clk_390` in 1: sole clock; every port is synchronous to it.
- `clk_390_rst_n` in 1: reset, asynchronous and active-low.
- `from_net_tdata` in 64: request data.
- `from_net_tkeep` in 8: ignored; requests are full 64-bit beats.
- `from_net_tuser` in 64: ignored.
- `from_net_tvalid` in 1: request beat valid.
- `from_net_tlast` in 1: last beat of a request.
- `from_net_tready` out 1: request beat accepted.
- `to_net_tdata` out 64: response data.
- `to_net_tkeep` out 8: constant 8'hFF while valid, 0 otherwise.
- `to_net_tuser` out 64: constant 0.
- `to_net_tvalid` out 1: response beat valid.
- `to_net_tlast` out 1: high on response beat 1.
- `to_net_tready` in 1: downstream ready.

## Operation
- **Request beat 0 (header):** [7:0] opcode, [31:16] request id, all other bits ignored. Opcodes: 0x01 GET, 0x02 SET, 0x03 DELETE.
- **Request beat 1:** 64-bit key.
- **Request beat 2:** 64-bit value, SET only.
- **Legal lengths:** GET and DELETE are 2 beats; SET is 3 beats.
- **Table:** 2^TABLE_AW entries, each holding {valid, key[63:0], value[63:0]}.
  - Valid bits are flops, cleared by reset.
  - Key/value storage is RAM with a 1-cycle registered read, not reset.
- **Index:** XOR-fold of the key into TABLE_AW-bit chunks, starting at bit 0; the final partial chunk is zero-padded.
- **GET:** hit (slot valid and key equal) gives status 0x00 with the stored value; otherwise status 0x01 with value 0.
- **SET:** unconditionally writes {1, key, value} to the slot, evicting any different key. Status 0x00.
- **DELETE:** on hit, clears valid and returns status 0x00; otherwise status 0x01 and the table is unchanged.
- **Bad opcode:** status 0x02. Beats are drained to tlast; the table is untouched.
- **Bad length:** tlast before the required beat count, or no tlast on the final required beat, gives status 0x03. Excess beats are drained to tlast; the table is untouched. Bad opcode takes precedence over bad length.
- **Response beat 0:** {32'h0, id[15:0], status[7:0], opcode[7:0]}, echoing the request opcode.
- **Response beat 1:** value (GET hit) or 64'h0, with tlast=1.
- **FSM states:** RX_HDR → RX_KEY → (RX_VAL | RX_DRAIN) → LOOKUP → EXEC → TX_HDR → TX_VAL → RX_HDR.
  - LOOKUP presents the read address.
  - EXEC compares and performs any write or valid-clear.
  - Error paths skip the table read and write but still pass through LOOKUP and EXEC, so latency is uniform.
- Requests are processed strictly one at a time, in order.

## Timing
- **`from_net_tready`:** high only in RX_HDR, RX_KEY, RX_VAL and RX_DRAIN. Low from the cycle after the last-beat handshake until the response tlast handshake completes.
- **Response latency:** with the last request beat accepted at edge E, `to_net_tvalid` rises after edge E+2 (beat 0). Beat 1 follows the beat-0 handshake, with no bubble when `to_net_tready` stays high.
- **Back-to-back requests:** `from_net_tready` reasserts the cycle after the beat-1 handshake, giving a minimum of 6 cycles per 2-beat request.
- **AXIS rules:** valid never depends on ready. Data, keep and last are held stable while tvalid=1 and tready=0.
- **Reset values:** `from_net_tready`=0, `to_net_tvalid`=0, `to_net_tlast`=0, `to_net_tdata`=0, `to_net_tkeep`=0, `to_net_tuser`=0. FSM goes to RX_HDR and all valid bits are cleared; `from_net_tready` rises the first cycle after reset release.
- **Reset mid-packet or mid-response:** the transaction is discarded. Any remaining input beats are parsed as a new header; upstream must avoid this.
- **Ordering:** a SET immediately followed by a GET of the same key returns the new value, because the write completes in EXEC before the next request is accepted.

## Test plan
- SET key 0x1122334455667788, value 0xDEADBEEFCAFEF00D, id 0x0001 → beat 0 = 0x0000000000010002, beat 1 = 0, tlast on beat 1, tvalid 2 cycles after the last-beat handshake.
- GET the same key, id 0x0002 → beat 0 = 0x0000000000020001, beat 1 = 0xDEADBEEFCAFEF00D.
- GET never-set key 0x42 → status 0x01 (beat 0 = 0x0000000000000101 for id 0), beat 1 = 0. DELETE 0x1122334455667788 → status 0x00; a following GET of that key → status 0x01.
- Collision (TABLE_AW=8): SET key 0x1 then SET key 0x100 (both index 1) → GET 0x1 returns status 0x01; GET 0x100 returns the value stored for 0x100.
- Opcode 0x7F in a 2-beat packet → status 0x02, table unchanged. SET with only 2 beats → status 0x03, no write. GET with 4 beats → status 0x03, extra beats drained.
- Hold `to_net_tready`=0 for 5 cycles during beat 0 → tdata, tkeep and tlast stable, `from_net_tready`=0. Assert reset mid-response → all outputs 0 immediately; a post-reset GET of any key → status 0x01.

Source files
------------

// File: rtl/lego_fpga_axis64_kvs.sv
// lego_fpga_axis64_kvs: on-chip direct-mapped key-value store answering GET/SET/DELETE requests over 64-bit AXI-Stream
// Ports:
//   clk_390, clk_390_rst_n : sole clock, asynchronous active-low reset
//   from_net_t*            : request stream; beat 0 header {id[31:16], opcode[7:0]}, beat 1 key, beat 2 value (SET)
//   to_net_t*              : 2-beat response; beat 0 {32'h0, id, status, opcode}, beat 1 value, tlast on beat 1
module lego_fpga_axis64_kvs #(
    parameter int TABLE_AW = 8
) (
    input  logic        clk_390,
    input  logic        clk_390_rst_n,
    input  logic [63:0] from_net_tdata,
    input  logic [7:0]  from_net_tkeep,
    input  logic [63:0] from_net_tuser,
    input  logic        from_net_tvalid,
    input  logic        from_net_tlast,
    output logic        from_net_tready,
    output logic [63:0] to_net_tdata,
    output logic [7:0]  to_net_tkeep,
    output logic [63:0] to_net_tuser,
    output logic        to_net_tvalid,
    output logic        to_net_tlast,
    input  logic        to_net_tready
);
    localparam int DEPTH = 1 << TABLE_AW;
    localparam int NCH = (64 + TABLE_AW - 1) / TABLE_AW;
    localparam logic [7:0] OP_GET = 8'h01;
    localparam logic [7:0] OP_SET = 8'h02;
    localparam logic [7:0] OP_DEL = 8'h03;

    typedef enum logic [2:0] {RX_HDR, RX_KEY, RX_VAL, RX_DRAIN, LOOKUP, EXEC, TX_HDR, TX_VAL} state_t;

    state_t              state_q, state_d;
    logic                run_q;
    logic [7:0]          op_q, op_d, st_q, st_d;
    logic [15:0]         id_q, id_d;
    logic [63:0]         key_q, key_d, val_q, val_d, rsp_q, rsp_d;
    logic                bad_len_q, bad_len_d;
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [63:0]         key_mem [DEPTH];
    logic [63:0]         val_mem [DEPTH];
    logic [63:0]         rd_key_q, rd_val_q;
    logic [TABLE_AW-1:0] idx;
    logic [NCH*TABLE_AW-1:0] key_pad;
    logic                bad_op, ok, hit, wr_en, rx_hs, tx_hs;
    logic                unused_ok;

    assign unused_ok = ^{from_net_tkeep, from_net_tuser};

    // XOR-fold of the key; the last chunk is zero-padded via key_pad
    always_comb begin
        key_pad = '0;
        key_pad[63:0] = key_q;
        idx = '0;
        for (int j = 0; j < NCH; j++) idx ^= key_pad[j*TABLE_AW +: TABLE_AW];
    end

    assign bad_op = !(op_q inside {OP_GET, OP_SET, OP_DEL});
    assign ok = !bad_op && !bad_len_q;
    assign hit = vld_q[idx] && (rd_key_q == key_q);
    assign wr_en = (state_q == EXEC) && ok && (op_q == OP_SET);

    assign from_net_tready = run_q && (state_q inside {RX_HDR, RX_KEY, RX_VAL, RX_DRAIN});
    assign to_net_tvalid = state_q inside {TX_HDR, TX_VAL};
    assign to_net_tlast = state_q == TX_VAL;
    assign to_net_tkeep = to_net_tvalid ? 8'hFF : 8'h00;
    assign to_net_tuser = '0;
    assign to_net_tdata = state_q == TX_HDR ? {32'h0, id_q, st_q, op_q} :
                          state_q == TX_VAL ? rsp_q : 64'h0;
    assign rx_hs = from_net_tvalid && from_net_tready;
    assign tx_hs = to_net_tvalid && to_net_tready;

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        id_d = id_q;
        key_d = key_q;
        val_d = val_q;
        bad_len_d = bad_len_q;
        st_d = st_q;
        rsp_d = rsp_q;
        vld_d = vld_q;
        case (state_q)
            RX_HDR: if (rx_hs) begin
                op_d = from_net_tdata[7:0];
                id_d = from_net_tdata[31:16];
                bad_len_d = from_net_tlast;
                state_d = from_net_tlast ? LOOKUP : RX_KEY;
            end
            RX_KEY: if (rx_hs) begin
                key_d = from_net_tdata;
                if (from_net_tlast) begin
                    bad_len_d = op_q == OP_SET;
                    state_d = LOOKUP;
                end else if (op_q == OP_SET) begin
                    state_d = RX_VAL;
                end else begin
                    bad_len_d = 1'b1;
                    state_d = RX_DRAIN;
                end
            end
            RX_VAL: if (rx_hs) begin
                val_d = from_net_tdata;
                bad_len_d = !from_net_tlast;
                state_d = from_net_tlast ? LOOKUP : RX_DRAIN;
            end
            RX_DRAIN: if (rx_hs && from_net_tlast) state_d = LOOKUP;
            LOOKUP: state_d = EXEC;
            EXEC: begin
                // read data for idx arrives here, one cycle after LOOKUP presented it
                st_d = bad_op ? 8'h02 : bad_len_q ? 8'h03 : (op_q == OP_SET || hit) ? 8'h00 : 8'h01;
                rsp_d = (ok && op_q == OP_GET && hit) ? rd_val_q : 64'h0;
                if (wr_en) vld_d[idx] = 1'b1;
                if (ok && op_q == OP_DEL && hit) vld_d[idx] = 1'b0;
                state_d = TX_HDR;
            end
            TX_HDR: if (tx_hs) state_d = TX_VAL;
            TX_VAL: if (tx_hs) state_d = RX_HDR;
            default: state_d = RX_HDR;
        endcase
    end

    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            state_q <= RX_HDR;
            run_q <= 1'b0;
            op_q <= '0;
            id_q <= '0;
            key_q <= '0;
            val_q <= '0;
            bad_len_q <= 1'b0;
            st_q <= '0;
            rsp_q <= '0;
            vld_q <= '0;
        end else begin
            state_q <= state_d;
            run_q <= 1'b1;
            op_q <= op_d;
            id_q <= id_d;
            key_q <= key_d;
            val_q <= val_d;
            bad_len_q <= bad_len_d;
            st_q <= st_d;
            rsp_q <= rsp_d;
            vld_q <= vld_d;
        end
    end

    // key/value RAM: registered read, no reset
    always_ff @(posedge clk_390) begin
        if (wr_en) begin
            key_mem[idx] <= key_q;
            val_mem[idx] <= val_q;
        end
        rd_key_q <= key_mem[idx];
        rd_val_q <= val_mem[idx];
    end
endmodule

// File: tb/tb_lego_fpga_axis64_kvs.sv
// tb_lego_fpga_axis64_kvs: directed plus randomized requests checked against a behavioural table model
module tb_lego_fpga_axis64_kvs;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] fd = '0, fu = '0;
    logic [7:0]  fk = '0;
    logic        fv = 1'b0, fl = 1'b0, fr;
    logic [63:0] td, tu;
    logic [7:0]  tk;
    logic        tv, tl, tr = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] ob0, ob1;

    bit          mvld [2**AW];
    logic [63:0] mkey [2**AW];
    logic [63:0] mval [2**AW];

    lego_fpga_axis64_kvs #(.TABLE_AW(AW)) dut (
        .clk_390(clk), .clk_390_rst_n(rst_n),
        .from_net_tdata(fd), .from_net_tkeep(fk), .from_net_tuser(fu),
        .from_net_tvalid(fv), .from_net_tlast(fl), .from_net_tready(fr),
        .to_net_tdata(td), .to_net_tkeep(tk), .to_net_tuser(tu),
        .to_net_tvalid(tv), .to_net_tlast(tl), .to_net_tready(tr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int fold(input logic [63:0] k);
        int r = 0;
        while (k != 0) begin
            r ^= int'(k % (64'd1 << AW));
            k = k >> AW;
        end
        return r;
    endfunction

    task automatic model(input logic [7:0] op, input int nb, input logic [63:0] key, input logic [63:0] val,
                         output logic [7:0] st, output logic [63:0] rv);
        int i = fold(key);
        bit hit = mvld[i] && (mkey[i] == key);
        rv = 64'h0;
        if (!(op inside {8'h01, 8'h02, 8'h03})) st = 8'h02;
        else if (nb != (op == 8'h02 ? 3 : 2)) st = 8'h03;
        else if (op == 8'h02) begin
            st = 8'h00;
            mvld[i] = 1'b1;
            mkey[i] = key;
            mval[i] = val;
        end else if (op == 8'h01) begin
            st = hit ? 8'h00 : 8'h01;
            rv = hit ? mval[i] : 64'h0;
        end else begin
            st = hit ? 8'h00 : 8'h01;
            if (hit) mvld[i] = 1'b0;
        end
    endtask

    task automatic req(input logic [7:0] op, input logic [15:0] id, input logic [63:0] key,
                       input logic [63:0] val, input int nb, input int hold, input bit abort);
        logic [63:0] beats [4];
        logic [7:0]  st;
        logic [63:0] rv, b0;
        beats[0] = {$urandom, id, 8'($urandom), op};
        beats[1] = key;
        beats[2] = val;
        beats[3] = {$urandom, $urandom};
        model(op, nb, key, val, st, rv);
        b0 = {32'h0, id, st, op};
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            fd = beats[b];
            fv = 1'b1;
            fl = (b == nb - 1);
            fk = 8'($urandom);
            fu = {$urandom, $urandom};
            for (int t = 0; !fr; t++) begin
                if (t == 50) begin
                    $display("FAIL from_net_tready_timeout: observed 0 expected 1");
                    $fatal(1);
                end
                @(negedge clk);
            end
            @(posedge clk);
        end
        @(negedge clk);
        fv = 1'b0;
        fl = 1'b0;
        tr = (hold == 0);
        chk("lat_e0_tvalid", tv, 0);
        chk("busy_fready", fr, 0);
        @(negedge clk);
        chk("lat_e1_tvalid", tv, 0);
        @(negedge clk);
        ob0 = td;
        chk("lat_e2_tvalid", tv, 1);
        chk("beat0_data", td, b0);
        chk("beat0_keep", tk, 8'hFF);
        chk("beat0_last", tl, 0);
        chk("tuser", tu, 0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_valid", tv, 1);
            chk("hold_data", td, b0);
            chk("hold_keep", tk, 8'hFF);
            chk("hold_last", tl, 0);
            chk("hold_fready", fr, 0);
        end
        if (abort) begin
            rst_n = 1'b0;
            #1;
            chk("rst_tvalid", tv, 0);
            chk("rst_tlast", tl, 0);
            chk("rst_tdata", td, 0);
            chk("rst_tkeep", tk, 0);
            chk("rst_tuser", tu, 0);
            chk("rst_fready", fr, 0);
            for (int i = 0; i < 2**AW; i++) mvld[i] = 1'b0;
            tr = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            #1 chk("rel_fready_low", fr, 0);
            @(negedge clk);
            chk("rel_fready_high", fr, 1);
            return;
        end
        tr = 1'b1;
        @(negedge clk);
        ob1 = td;
        chk("beat1_valid", tv, 1);
        chk("beat1_data", td, rv);
        chk("beat1_last", tl, 1);
        @(negedge clk);
        chk("idle_tvalid", tv, 0);
        chk("rearm_fready", fr, 1);
    endtask

    initial begin
        logic [63:0] pool [8];
        logic [63:0] k1;
        k1 = 64'h1122334455667788;
        #1;
        chk("reset_fready", fr, 0);
        chk("reset_tvalid", tv, 0);
        chk("reset_tlast", tl, 0);
        chk("reset_tdata", td, 0);
        chk("reset_tkeep", tk, 0);
        chk("reset_tuser", tu, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_fready_low", fr, 0);
        @(negedge clk);
        chk("rel_fready_high", fr, 1);

        req(8'h02, 16'h0001, k1, 64'hDEADBEEFCAFEF00D, 3, 0, 0);
        chk("tp_set_b0", ob0, 64'h0000000000010002);
        chk("tp_set_b1", ob1, 64'h0);
        req(8'h01, 16'h0002, k1, 64'h0, 2, 0, 0);
        chk("tp_get_b0", ob0, 64'h0000000000020001);
        chk("tp_get_b1", ob1, 64'hDEADBEEFCAFEF00D);
        req(8'h01, 16'h0000, 64'h42, 64'h0, 2, 0, 0);
        chk("tp_miss_b0", ob0, 64'h0000000000000101);
        chk("tp_miss_b1", ob1, 64'h0);
        req(8'h03, 16'h0003, k1, 64'h0, 2, 0, 0);
        chk("tp_del_status", ob0[15:8], 8'h00);
        req(8'h01, 16'h0004, k1, 64'h0, 2, 0, 0);
        chk("tp_get_deleted", ob0[15:8], 8'h01);

        req(8'h02, 16'h0005, 64'h1, 64'hAAAA0001, 3, 0, 0);
        req(8'h02, 16'h0006, 64'h100, 64'hBBBB0100, 3, 0, 0);
        req(8'h01, 16'h0007, 64'h1, 64'h0, 2, 0, 0);
        chk("tp_evicted", ob0[15:8], 8'h01);
        req(8'h01, 16'h0008, 64'h100, 64'h0, 2, 0, 0);
        chk("tp_collide_val", ob1, 64'hBBBB0100);

        req(8'h7F, 16'h0009, 64'h100, 64'h0, 2, 0, 0);
        chk("tp_badop", ob0[15:8], 8'h02);
        req(8'h01, 16'h000A, 64'h100, 64'h0, 2, 0, 0);
        chk("tp_badop_untouched", ob1, 64'hBBBB0100);
        req(8'h02, 16'h000B, 64'h55, 64'h1234, 2, 0, 0);
        chk("tp_short_set", ob0[15:8], 8'h03);
        req(8'h01, 16'h000C, 64'h55, 64'h0, 2, 0, 0);
        chk("tp_short_nowrite", ob0[15:8], 8'h01);
        req(8'h01, 16'h000D, 64'h100, 64'h0, 4, 0, 0);
        chk("tp_long_get", ob0[15:8], 8'h03);
        req(8'h01, 16'h000E, 64'h100, 64'h0, 2, 5, 0);
        chk("tp_after_drain", ob1, 64'hBBBB0100);

        for (int i = 0; i < 4; i++) begin
            pool[i] = {$urandom, $urandom};
            pool[i+4] = pool[i] ^ 64'h0303;
        end
        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] op = r < 4 ? 8'h01 : r < 7 ? 8'h02 : r < 9 ? 8'h03 : 8'(8'h04 + $urandom_range(0, 250));
            int nb = (op == 8'h02) ? 3 : 2;
            if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, 4);
            req(op, 16'($urandom), pool[$urandom_range(0, 7)], {$urandom, $urandom}, nb,
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0, 0);
        end

        req(8'h02, 16'h00F0, k1, 64'h5555AAAA, 3, 0, 0);
        req(8'h01, 16'h00F1, k1, 64'h0, 2, 2, 1);
        req(8'h01, 16'h00F2, k1, 64'h0, 2, 0, 0);
        chk("tp_post_reset_miss", ob0[15:8], 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
